// File: rtl/profiler_pkg.sv
// Shared types and constants for the instruction-mix profiler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package profiler_pkg;

  // Scan controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Opcode field values (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Destination registers tracked for R-type words (instruction bits 15:11)
  localparam logic [4:0] RD_3 = 5'd3;
  localparam logic [4:0] RD_4 = 5'd4;
  localparam logic [4:0] RD_5 = 5'd5;

  // All profile counters, bundled so they clear and hold together
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] i;
    logic [3:0] j;
    logic [3:0] c3;
    logic [3:0] c4;
    logic [3:0] c5;
  } cnt_t;

  // 4-bit counter step by a single flag
  function automatic logic [3:0] bump(input logic [3:0] v, input logic en);
    return v + {3'b000, en};
  endfunction

endpackage

// File: rtl/instr_classify.sv
// Decodes one instruction word into class flags and tracked-rd flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input word.
module instr_classify
  import profiler_pkg::*;
(
  input  logic [31:0] word,
  output logic        is_r,
  output logic        is_i,
  output logic        is_j,
  output logic        rd_is3,
  output logic        rd_is4,
  output logic        rd_is5
);

  logic [5:0] opcode;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode = word[31:26];
  assign rd     = word[15:11];

  // Remaining fields carry no profile information
  assign unused_fields = ^{word[25:16], word[10:0]};

  // Class decode; anything not R or J counts as I-type
  always_comb begin
    is_r   = (opcode == OP_RTYPE);
    is_j   = (opcode == OP_J) || (opcode == OP_JAL);
    is_i   = !is_r && !is_j;
    rd_is3 = is_r && (rd == RD_3);
    rd_is4 = is_r && (rd == RD_4);
    rd_is5 = is_r && (rd == RD_5);
  end

endmodule

// File: rtl/instr_profile_ctrl.sv
// Fetches NUM_INSTR words from instruction memory and counts R/I/J types and rd 3/4/5 writes.
// Latency: one REQ cycle plus the memory wait per word; 2*NUM_INSTR edges with zero-wait memory.
// Backpressure: one outstanding read; the controller holds in WAIT until mem_valid returns.
module instr_profile_ctrl
  import profiler_pkg::*;
#(
  parameter int NUM_INSTR = 8,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [31:0]       mem_data,
  input  logic [1:0]        sel,
  output logic [7:0]        led,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [4:0]        TOTAL = 5'(NUM_INSTR);

  state_t     state;
  state_t     state_nxt;
  logic       clear;
  logic       accept;
  logic [3:0] proc_cnt;
  cnt_t       cnt;

  logic is_r;
  logic is_i;
  logic is_j;
  logic rd_is3;
  logic rd_is4;
  logic rd_is5;

  instr_classify u_classify (
    .word   (mem_data),
    .is_r   (is_r),
    .is_i   (is_i),
    .is_j   (is_j),
    .rd_is3 (rd_is3),
    .rd_is4 (rd_is4),
    .rd_is5 (rd_is5)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control strobes; start is only honoured while not scanning
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    accept    = 1'b0;
    mem_req   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req   = 1'b1;
        busy      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (mem_valid) begin
          accept    = 1'b1;
          state_nxt = (({1'b0, proc_cnt} + 5'd1) < TOTAL) ? REQ : DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          clear     = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address, progress and profile counters; a new scan starts from a clean slate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= BASE;
      proc_cnt <= 4'd0;
      cnt      <= '0;
    end else if (clear) begin
      mem_addr <= BASE;
      proc_cnt <= 4'd0;
      cnt      <= '0;
    end else if (accept) begin
      mem_addr <= mem_addr + 1'b1;
      proc_cnt <= proc_cnt + 4'd1;
      cnt.r    <= bump(cnt.r,  is_r);
      cnt.i    <= bump(cnt.i,  is_i);
      cnt.j    <= bump(cnt.j,  is_j);
      cnt.c3   <= bump(cnt.c3, rd_is3);
      cnt.c4   <= bump(cnt.c4, rd_is4);
      cnt.c5   <= bump(cnt.c5, rd_is5);
    end
  end

  // LED page mux straight from registered state
  always_comb begin
    led = 8'h00;
    case (sel)
      2'b00:   led = {cnt.r,  cnt.i};
      2'b01:   led = {cnt.j,  cnt.c3};
      2'b10:   led = {cnt.c4, cnt.c5};
      default: led = {busy, done, 2'b00, proc_cnt};
    endcase
  end

endmodule

// File: tb/tb_instr_profile_ctrl.sv
// Bench for instr_profile_ctrl: memory responder, abstract scan model, per-cycle compare.
// Latency: n/a.
// Backpressure: responder inserts fixed or random wait cycles per read.
module tb_instr_profile_ctrl;

  localparam int N    = 8;
  localparam int BASE = 58;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_valid = 1'b0;
  logic [31:0]   mem_data = 32'h0;
  logic [1:0]    sel = 2'b00;
  logic [7:0]    led;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] mem [64];
  logic [31:0] prog [8];

  // responder controls
  bit          spur = 1'b0;
  bit          wait_rand = 1'b0;
  int          wait_cfg = 0;
  int          served_cnt = 0;
  logic [31:0] spur_word = 32'h00431820;

  // abstract scan model
  bit m_scan = 1'b0;
  bit m_fin = 1'b0;
  bit m_req_due = 1'b0;
  bit m_waiting = 1'b0;
  int m_n = 0;
  int mc [6];

  int led_obs [4];

  instr_profile_ctrl #(
    .NUM_INSTR (N),
    .BASE_ADDR (BASE),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_data  (mem_data),
    .sel       (sel),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // 0 = R-type, 1 = I-type, 2 = J-type (counter slot numbering of mc[])
  function automatic int kind_of(input logic [31:0] w);
    int op;
    op = int'(w >> 26);
    if (op == 0) return 0;
    if (op == 2 || op == 3) return 2;
    return 1;
  endfunction

  // rd counter slot 3..5 for R-type words writing r3..r5, else -1
  function automatic int rd_slot(input logic [31:0] w);
    int rd;
    rd = int'((w >> 11) % 32);
    if (kind_of(w) == 0 && rd >= 3 && rd <= 5) return rd;
    return -1;
  endfunction

  function automatic int page(input int s, input int c0, input int c1, input int c2,
                              input int c3, input int c4, input int c5,
                              input int b, input int d, input int n);
    case (s)
      0:       return c0 * 16 + c1;
      1:       return c2 * 16 + c3;
      2:       return c4 * 16 + c5;
      default: return b * 128 + d * 64 + n;
    endcase
  endfunction

  // Expected page after a complete scan, counted directly from memory contents
  function automatic int ref_page(input int s);
    int c [6];
    int r;
    for (int k = 0; k < 6; k++) c[k] = 0;
    for (int k = 0; k < N; k++) begin
      c[kind_of(mem[(BASE + k) % 64])]++;
      r = rd_slot(mem[(BASE + k) % 64]);
      if (r > 0) c[r]++;
    end
    return page(s, c[0], c[1], c[2], c[3], c[4], c[5], 0, 1, N);
  endfunction

  // Transaction-level model: a scan is a sequence of request/response pairs
  always @(posedge clk or posedge rst) begin : model
    int k;
    int r;
    if (rst) begin
      m_scan <= 1'b0; m_fin <= 1'b0; m_req_due <= 1'b0; m_waiting <= 1'b0; m_n <= 0;
      for (int q = 0; q < 6; q++) mc[q] <= 0;
    end else if (!m_scan && start) begin
      m_scan <= 1'b1; m_fin <= 1'b0; m_req_due <= 1'b1; m_waiting <= 1'b0; m_n <= 0;
      for (int q = 0; q < 6; q++) mc[q] <= 0;
    end else if (m_scan) begin
      if (m_req_due) begin
        m_req_due <= 1'b0;
        m_waiting <= 1'b1;
      end else if (m_waiting && mem_valid) begin
        k = kind_of(mem_data);
        r = rd_slot(mem_data);
        mc[k] <= mc[k] + 1;
        if (r > 0) mc[r] <= mc[r] + 1;
        m_n       <= m_n + 1;
        m_waiting <= 1'b0;
        if (m_n + 1 == N) begin
          m_scan <= 1'b0;
          m_fin  <= 1'b1;
        end else begin
          m_req_due <= 1'b1;
        end
      end
    end
  end

  // Memory responder: one outstanding read, address must hold until answered
  initial begin : responder
    bit pend;
    int rem;
    int pend_addr;
    pend = 1'b0; rem = 0; pend_addr = 0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      mem_data  = $urandom;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("addr_hold", int'(mem_addr), pend_addr);
          if (rem == 0) begin
            mem_valid = 1'b1;
            mem_data  = mem[pend_addr];
            pend      = 1'b0;
            served_cnt++;
          end else begin
            rem--;
          end
        end
        if (mem_req) begin
          pend      = 1'b1;
          pend_addr = int'(mem_addr);
          rem       = wait_rand ? int'($urandom_range(0, 3)) : wait_cfg;
        end
      end
      if (spur) begin
        mem_valid = 1'b1;
        mem_data  = spur_word;
      end
    end
  end

  // Per-cycle compare of every output against the model
  initial begin : compare
    forever begin
      @(negedge clk);
      #1;
      chk("mem_req", int'(mem_req), int'(m_req_due));
      chk("busy", int'(busy), int'(m_scan));
      chk("done", int'(done), int'(m_fin));
      chk("mem_addr", int'(mem_addr), (BASE + m_n) % 64);
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        #1;
        led_obs[s] = int'(led);
        chk($sformatf("led_sel%0d", s), int'(led),
            page(s, mc[0], mc[1], mc[2], mc[3], mc[4], mc[5], int'(m_scan), int'(m_fin), m_n));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #6;
  endtask

  task automatic run_scan(input bit inj, input bit spur_req, output int lat);
    int e0;
    bit got;
    tick();
    start = 1'b1;
    e0 = cyc + 1;
    tick();
    start = 1'b0;
    spur = spur_req;
    tick();
    spur = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (inj) start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    chk("done_seen", int'(got), 1);
    lat = cyc - e0;
    #6;
  endtask

  task automatic chk_prog_pages(input string tag);
    chk({tag, "_sel00"}, led_obs[0], 'h42);
    chk({tag, "_sel01"}, led_obs[1], 'h21);
    chk({tag, "_sel10"}, led_obs[2], 'h11);
    chk({tag, "_sel11"}, led_obs[3], 'h48);
  endtask

  initial begin : main
    int lat;
    int s0;
    logic [31:0] w;
    prog[0] = 32'h00431820; prog[1] = 32'h00A62020; prog[2] = 32'h00E62820; prog[3] = 32'h00000000;
    prog[4] = 32'h08000004; prog[5] = 32'h0C000004; prog[6] = 32'h20080005; prog[7] = 32'h8C090000;
    for (int k = 0; k < 64; k++) mem[k] = $urandom;
    for (int k = 0; k < N; k++) mem[(BASE + k) % 64] = prog[k];

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    settle();
    chk("rst_addr", int'(mem_addr), BASE);
    chk("rst_sel00", led_obs[0], 0);
    chk("rst_sel11", led_obs[3], 0);

    // stray read data while idle
    tick(); spur = 1'b1; tick(); spur = 1'b0;
    settle();
    chk("idle_spur_sel00", led_obs[0], 0);
    chk("idle_spur_sel11", led_obs[3], 0);

    // zero-wait scan, address range wraps past the top of memory
    wait_cfg = 0;
    run_scan(1'b0, 1'b0, lat);
    chk("lat_zero_wait", lat, 16);
    chk_prog_pages("run1");

    // restart from DONE with start pulses during the scan
    run_scan(1'b1, 1'b0, lat);
    chk("lat_rerun", lat, 16);
    chk_prog_pages("run2");

    // three wait cycles per read plus stray data during REQ
    wait_cfg = 3;
    run_scan(1'b0, 1'b1, lat);
    chk("lat_wait3", lat, 40);
    chk_prog_pages("wait3");

    // abort after the fourth word, then stray data after release
    wait_cfg = 1;
    tick(); start = 1'b1; tick(); start = 1'b0;
    s0 = served_cnt;
    for (int i = 0; i < 200 && served_cnt < s0 + 4; i++) tick();
    chk("reached_4th", int'(served_cnt >= s0 + 4), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    settle();
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_addr", int'(mem_addr), BASE);
    chk("abort_sel00", led_obs[0], 0);
    chk("abort_sel11", led_obs[3], 0);
    spur = 1'b1; tick(); spur = 1'b0;
    settle();
    chk("late_valid_sel00", led_obs[0], 0);
    chk("late_valid_sel11", led_obs[3], 0);
    wait_cfg = 0;
    run_scan(1'b0, 1'b0, lat);
    chk("lat_after_abort", lat, 16);
    chk_prog_pages("after_abort");

    // random programs with random memory latency
    wait_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin
        w = $urandom;
        case ($urandom_range(0, 3))
          0:       w[31:26] = 6'd0;
          1:       w[31:26] = 6'd2;
          2:       w[31:26] = 6'd3;
          default: w[31:26] = 6'($urandom_range(0, 63));
        endcase
        w[15:11] = 5'($urandom_range(0, 7));
        mem[(BASE + k) % 64] = w;
      end
      run_scan(1'b1, 1'b0, lat);
      for (int s = 0; s < 4; s++) chk($sformatf("rand%0d_page%0d", r, s), led_obs[s], ref_page(s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_profile_ctrl.md
INSTR_PROFILE_CTRL -- requirements
Module: instr_profile_ctrl

Interface
REQ-001 Parameter NUM_INSTR, default 8, number of instruction words scanned per run; legal range 1..15.
REQ-002 Parameter BASE_ADDR, default 0, first word address fetched.
REQ-003 Parameter ADDR_W, default 6, memory address width (64-word instruction file).
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begin a scan; sampled only in IDLE or DONE.
REQ-007 mem_req  out  1  one-cycle read request to instruction memory.
REQ-008 mem_addr  out  ADDR_W  read address; valid while mem_req high, held stable until the matching mem_valid.
REQ-009 mem_valid  in  1  read data valid; at least 1 cycle after mem_req, any number of wait cycles.
REQ-010 mem_data  in  32  instruction word, qualified by mem_valid.
REQ-011 sel  in  2  LED page select.
REQ-012 led  out  8  selected counter page.
REQ-013 busy  out  1  high in REQ and WAIT.
REQ-014 done  out  1  high in DONE.

Function
REQ-015 FSM states IDLE, REQ, WAIT, DONE shall be used; IDLE/DONE --start--> REQ (all counters cleared, mem_addr=BASE_ADDR); REQ -> WAIT unconditionally; WAIT --mem_valid--> REQ when proc_cnt+1 < NUM_INSTR, else DONE; WAIT holds without mem_valid.
REQ-016 mem_req shall be high exactly during REQ; mem_valid outside WAIT shall be ignored.
REQ-017 On mem_valid in WAIT, the word shall be classified and counters updated in that same edge; proc_cnt and mem_addr shall increment by 1.
REQ-018 Classification by opcode mem_data[31:26]: 000000 -> r_cnt++; 000010 or 000011 -> j_cnt++; all others -> i_cnt++.
REQ-019 For R-type only, rd = mem_data[15:11]: 3 -> c3++, 4 -> c4++, 5 -> c5++; other rd values add no rd count.
REQ-020 All counters shall be 4 bits; no wrap is possible within the legal NUM_INSTR range.
REQ-021 led (combinational from registers): sel=00 {r_cnt,i_cnt}; 01 {j_cnt,c3}; 10 {c4,c5}; 11 {busy,done,2'b00,proc_cnt}.
REQ-022 Counters shall hold their values in DONE until the next start or reset; start while busy shall be ignored.
REQ-023 Latency: start sampled at edge E0 -> mem_req high after E0; with zero-wait memory, done rises after edge E0+2*NUM_INSTR.
REQ-024 mem_addr shall wrap modulo 2^ADDR_W if BASE_ADDR+NUM_INSTR exceeds the address space.

Reset
REQ-025 rst high shall immediately force IDLE, mem_req=0, mem_addr=BASE_ADDR, proc_cnt and all counters 0, busy=0, done=0, led=0x00 for sel 00/01/10.
REQ-026 Reset mid-scan shall abort the scan; a mem_valid arriving after reset release shall be ignored (state IDLE).

Structure
REQ-027 Shared package profiler_pkg shall hold the state enum, opcode constants OP_RTYPE=000000, OP_J=000010, OP_JAL=000011, and rd constants 3/4/5.
REQ-028 Combinational sub-module instr_classify (in: 32-bit word; out: is_r, is_i, is_j, rd_is3, rd_is4, rd_is5) shall do the decode; the controller owns FSM, address and counters.

Verification
REQ-029 Zero-wait memory, NUM_INSTR=8, words 00431820,00A62020,00E62820,00000000,08000004,0C000004,20080005,8C090000 -> led sel00=0x42, sel01=0x21, sel10=0x11, sel11=0x48; done after edge E0+16.
REQ-030 Same program, 3 wait cycles per read -> identical counts, mem_addr stable during each wait, done after edge E0+40.
REQ-031 Spurious mem_valid in IDLE and in REQ -> counters unchanged, proc_cnt unchanged.
REQ-032 rst asserted after 4th mem_valid, then released -> all outputs 0, state IDLE; late mem_valid ignored; new start rescans from BASE_ADDR with fresh counts.
REQ-033 start pulsed in WAIT -> ignored; start in DONE -> counters cleared, second run yields same values as first.
